// File: rtl/div_unit_pkg.sv
// Shared pipeline types for the iterative divider: operation and FSM encodings,
// iteration count and sign helpers.
`timescale 1ns/1ps
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER = 32;
    localparam int XLEN     = 32;

    // Two's-complement negate when en is set; used for both abs() and sign fix-up.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] val, input logic en);
        return en ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
`timescale 1ns/1ps
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  dbit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  qbit_o
);

    logic [DATA_WIDTH:0] shifted;

    // The partial remainder stays below the divisor, so the difference always fits.
    always_comb begin
        shifted = {rem_i, dbit_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? (shifted[DATA_WIDTH-1:0] - divisor_i) : shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU) with valid/ready handshakes,
// one quotient bit per cycle, early exit for divide-by-zero and signed overflow.
`timescale 1ns/1ps
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [1:0]            div_op,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic is_rem_q, is_rem_d;

    div_op_e op_in;
    logic accept, op_signed, op_is_rem, div_zero, ovf, special, last_iter;
    logic [DATA_WIDTH-1:0] step_rem, quo_next;
    logic step_qbit;

    assign op_in     = div_op_e'(div_op);
    assign accept    = req_valid && req_ready;
    assign op_signed = (op_in == DIV) || (op_in == REM);
    assign op_is_rem = (op_in == REM) || (op_in == REMU);
    assign div_zero  = (op2 == '0);
    assign ovf       = op_signed && (op1 == INT_MIN) && (op2 == '1);
    assign special   = div_zero || ovf;
    assign last_iter = (cnt_q == 5'(DIV_ITER - 1));
    assign quo_next  = {quo_q[DATA_WIDTH-2:0], step_qbit};

    // The quotient register doubles as the dividend shifter: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .dbit_i    (quo_q[DATA_WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !flush;
        busy       = (state_q != IDLE);
        resp_valid = (state_q == DONE);
        result     = resp_valid ? res_q : '0;
    end

    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = cond_neg(op1, op_signed && op1[DATA_WIDTH-1]);
            dvsr_d    = cond_neg(op2, op_signed && op2[DATA_WIDTH-1]);
            neg_quo_d = op_signed && (op1[DATA_WIDTH-1] ^ op2[DATA_WIDTH-1]);
            neg_rem_d = op_signed && op1[DATA_WIDTH-1];
            is_rem_d  = op_is_rem;
            if (div_zero) begin
                res_d = op_is_rem ? op1 : '1;
            end else if (ovf) begin
                res_d = op_is_rem ? '0 : INT_MIN;
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 5'd1;
            quo_d = quo_next;
            rem_d = step_rem;
            if (last_iter) begin
                res_d = is_rem_q ? cond_neg(step_rem, neg_rem_q) : cond_neg(quo_next, neg_quo_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand and result width; only 32 is supported.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn: input, 1 bit, asynchronous active-low reset.
REQ-005 Port req_valid: input, 1 bit, a divide request is presented.
REQ-006 Port req_ready: output, 1 bit, the unit can accept a request this cycle.
REQ-007 Port op1: input, 32 bits, dividend, taken from the ALU operand-1 selection.
REQ-008 Port op2: input, 32 bits, divisor, taken from the ALU operand-2 selection.
REQ-009 Port div_op: input, DivOp (2 bits), one of DIV, DIVU, REM, REMU.
REQ-010 Port flush: input, 1 bit, pipeline flush that kills any in-flight operation.
REQ-011 Port resp_valid: output, 1 bit, result is available.
REQ-012 Port resp_ready: input, 1 bit, the consumer takes the result this cycle.
REQ-013 Port result: output, 32 bits, quotient or remainder.
REQ-014 Port busy: output, 1 bit, high whenever the state is not IDLE; it stalls the issue stage.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 The block SHALL drive req_ready = (state == IDLE) && !flush.
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready; the block latches op1, op2 and div_op at that edge.
REQ-018 Special case, divisor == 0: the FSM goes IDLE->DONE directly; the quotient is 0xFFFFFFFF and the remainder is op1 (signed and unsigned).
REQ-019 Special case, DIV/REM with op1 == 0x80000000 and op2 == 0xFFFFFFFF: the FSM goes IDLE->DONE; the quotient is 0x80000000 and the remainder is 0.
REQ-020 Otherwise the FSM goes IDLE->CALC.
REQ-021 In CALC the block SHALL run a restoring radix-2 division on operand magnitudes (signed ops take absolute values), one quotient bit per cycle, for exactly 32 cycles, counted by a 5-bit iteration counter; it then moves CALC->DONE.
REQ-022 Sign correction: the quotient is negated when the operand signs differ (signed ops); the remainder takes the dividend's sign.
REQ-023 resp_valid SHALL be high exactly in DONE; the latency is 1 cycle (special cases) or 33 cycles (normal) from the accepting edge to resp_valid high.
REQ-024 result SHALL be the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-025 result SHALL be stable while resp_valid && !resp_ready.
REQ-026 DONE->IDLE SHALL occur on an edge with resp_ready high; a new request is accepted no earlier than the next cycle.
REQ-027 flush high in any state SHALL force IDLE at the next edge; resp_valid is low from that edge and no result is delivered.
REQ-028 flush and req_valid high together: the request SHALL NOT be accepted.
REQ-029 flush and resp_ready high together in DONE: the block goes to IDLE, and the handshake counts as consumed.
REQ-030 result SHALL be 0 whenever resp_valid is low.

Reset
REQ-031 When rstn is low, asynchronously: state = IDLE, counter = 0, quotient, remainder and latched operands = 0; resp_valid = 0, busy = 0, result = 0.
REQ-032 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; after release req_ready is high on the first cycle.

Structure
REQ-033 The DivOp enum, the DivState enum and the constant DIV_ITER = 32 SHALL live in the shared pipeline types package.
REQ-034 One combinational sub-module, div_step, SHALL perform a single restoring shift/subtract iteration (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit).
REQ-035 The issue stage SHALL route DIV-class operations to this block and stall on busy.

Verification
REQ-036 DIVU op1=100, op2=7 -> result 14, resp_valid exactly 33 cycles after acceptance; REMU with the same operands -> 2.
REQ-037 DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with resp_valid 1 cycle after acceptance.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM with the same operands -> 0, both with 1-cycle latency.
REQ-040 Flush at the 10th CALC cycle -> resp_valid never rises and req_ready is high the next cycle; a following DIVU 9/3 -> 3.
REQ-041 resp_ready held low for 5 cycles in DONE -> result and resp_valid held stable, busy high and req_ready low throughout; rstn pulsed mid-CALC -> all outputs 0 immediately.
